// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects the start/stop/add buttons; pulses appear DEBOUNCE_CYCLES+2 edges after a raw edge.
// Fully registered with no backpressure. Add optionally auto-repeats while held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_raw,
    input  logic       stop_raw,
    input  logic       add_raw,
    output logic       start,
    output logic       stop,
    output logic       add,
    output logic [2:0] btn_level
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam bit            REP_ON      = (REPEAT_EN != 0);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rstate_t;

    logic [2:0]    raw, s1, s2, stable, flip, rise, stable_nxt;
    logic [CW-1:0] cnt [3];
    logic [RW-1:0] rcnt;
    rstate_t       state;

    assign raw       = {add_raw, stop_raw, start_raw};
    assign btn_level = stable;

    always_comb begin
        flip = '0;
        for (int b = 0; b < 3; b++) begin
            flip[b] = (s2[b] != stable[b]) && (cnt[b] == CNT_LAST);
        end
        rise       = flip & s2;
        stable_nxt = stable ^ flip;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int b = 0; b < 3; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            s1     <= raw;
            s2     <= s1;
            stable <= stable_nxt;
            // Any sample that agrees with the stable level restarts the integration.
            for (int b = 0; b < 3; b++) begin
                if (s2[b] == stable[b] || flip[b]) begin
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start <= 1'b0;
            stop  <= 1'b0;
            add   <= 1'b0;
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            // Stop wins a simultaneous press; the start press is discarded.
            start <= rise[0] & ~rise[1];
            stop  <= rise[1];
            add   <= rise[2];
            if (!stable_nxt[2]) begin
                state <= IDLE;
                rcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise[2] && REP_ON) begin
                            state <= DELAY;
                            rcnt  <= '0;
                        end
                    end
                    DELAY: begin
                        if (rcnt == DELAY_LAST) begin
                            add   <= 1'b1;
                            state <= REPEAT;
                            rcnt  <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rcnt == PERIOD_LAST) begin
                            add  <= 1'b1;
                            rcnt <= '0;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed press/bounce/repeat/reset cases plus a random soak,
// every cycle compared against a timing model derived from the debounce and repeat rules.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int REN = 1;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_raw = 1'b0, stop_raw = 1'b0, add_raw = 1'b0;
    logic       start, stop, add;
    logic [2:0] btn_level;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0, stop_cnt = 0;
    int last_start = -1, last_stop = -1;
    int add_q[$];

    // model state
    bit   h1[3], h2[3], stab[3];
    int   streak[3];
    int   age = 0;
    bit   active = 0;
    logic e_start = 0, e_stop = 0, e_add = 0;
    logic [2:0] e_level = '0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_EN(REN),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_raw(start_raw),
        .stop_raw(stop_raw),
        .add_raw(add_raw),
        .start(start),
        .stop(stop),
        .add(add),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: s2 is the raw level two edges back; a level flips after DEB consecutive
    // disagreeing samples; add repeats at RD, RD+RP, RD+2RP... cycles after its press pulse.
    initial begin
        bit r[3];
        bit rise[3];
        bit s;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int b = 0; b < 3; b++) begin
                    h1[b] = 0; h2[b] = 0; stab[b] = 0; streak[b] = 0;
                end
                age = 0; active = 0;
                e_start = 0; e_stop = 0; e_add = 0; e_level = '0;
            end else begin
                r = '{start_raw, stop_raw, add_raw};
                for (int b = 0; b < 3; b++) begin
                    s = h2[b];
                    h2[b] = h1[b];
                    h1[b] = r[b];
                    rise[b] = 0;
                    if (s != stab[b]) begin
                        streak[b]++;
                        if (streak[b] == DEB) begin
                            stab[b] = s;
                            streak[b] = 0;
                            rise[b] = s;
                        end
                    end else begin
                        streak[b] = 0;
                    end
                end
                e_stop  = rise[1];
                e_start = rise[0] && !rise[1];
                if (rise[2]) begin
                    active = 1; age = 0; e_add = 1;
                end else if (active && stab[2]) begin
                    age++;
                    e_add = (REN != 0) && ((age == RD) || (age > RD && (age - RD) % RP == 0));
                end else begin
                    active = 0; e_add = 0;
                end
                e_level = {stab[2], stab[1], stab[0]};
            end
        end
    end

    // Per-cycle comparison and pulse logging, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("start", {2'b0, start}, {2'b0, e_start});
            check("stop", {2'b0, stop}, {2'b0, e_stop});
            check("add", {2'b0, add}, {2'b0, e_add});
            check("btn_level", btn_level, e_level);
            if (start === 1'b1) begin start_cnt++; last_start = cyc; end
            if (stop === 1'b1) begin stop_cnt++; last_stop = cyc; end
            if (add === 1'b1) add_q.push_back(cyc);
        end
    end

    initial begin
        int c0, c1, base, base2;
        int hold_left[3];
        bit lvl[3];

        tick(3);
        check("reset_level", btn_level, 3'b000);
        check("reset_pulses", {start, stop, add}, 3'b000);
        rst = 1'b0;
        tick(3);

        // 1: clean start press and release
        c0 = cyc; base = start_cnt;
        start_raw = 1'b1;
        tick(20);
        check("t1_count", 3'(start_cnt - base), 3'd1);
        check("t1_when", 3'(last_start - c0), 3'd6);
        check("t1_level", btn_level, 3'b001);
        c1 = cyc;
        start_raw = 1'b0;
        tick(5);
        check("t1_level_hold", btn_level, 3'b001);
        tick(1);
        check("t1_level_rel", btn_level, 3'b000);
        tick(10);
        check("t1_no_rel_pulse", 3'(start_cnt - base), 3'd1);

        // 2: bouncing stop
        c0 = cyc; base = stop_cnt;
        stop_raw = 1'b1; tick(1);
        stop_raw = 1'b0; tick(1);
        stop_raw = 1'b1; tick(2);
        stop_raw = 1'b0; tick(1);
        stop_raw = 1'b1; tick(15);
        check("t2_count", 3'(stop_cnt - base), 3'd1);
        check("t2_when", 4'(last_stop - c0) == 4'd11 ? 3'd1 : 3'd0, 3'd1);
        stop_raw = 1'b0;
        tick(12);

        // 3: simultaneous start and stop
        c0 = cyc; base = start_cnt; base2 = stop_cnt;
        start_raw = 1'b1; stop_raw = 1'b1;
        tick(12);
        check("t3_stop_count", 3'(stop_cnt - base2), 3'd1);
        check("t3_stop_when", 3'(last_stop - c0), 3'd6);
        check("t3_start_dropped", 3'(start_cnt - base), 3'd0);
        check("t3_level", btn_level, 3'b011);
        start_raw = 1'b0; stop_raw = 1'b0;
        tick(12);

        // 4: add held 30 cycles with auto-repeat
        c0 = cyc; base = add_q.size();
        add_raw = 1'b1;
        tick(30);
        add_raw = 1'b0;
        tick(15);
        check("t4_count", 3'(add_q.size() - base), 3'd0 + 3'(8 % 8));
        check("t4_count8", (add_q.size() - base == 8) ? 3'd1 : 3'd0, 3'd1);
        check("t4_first", 3'(add_q[base] - c0), 3'd6);
        check("t4_rep1", (add_q[base + 1] - c0 == 16) ? 3'd1 : 3'd0, 3'd1);
        check("t4_rep2", (add_q[base + 2] - c0 == 19) ? 3'd1 : 3'd0, 3'd1);
        check("t4_last", (add_q[base + 7] - c0 == 34) ? 3'd1 : 3'd0, 3'd1);
        check("t4_level", btn_level, 3'b000);

        // 5: reset while add is mid-delay
        c0 = cyc;
        add_raw = 1'b1;
        tick(9);
        check("t5_level_pre", btn_level, 3'b100);
        rst = 1'b1;
        #1;
        check("t5_rst_level", btn_level, 3'b000);
        check("t5_rst_pulse", {start, stop, add}, 3'b000);
        base = add_q.size();
        tick(2);
        rst = 1'b0;
        tick(17);
        check("t5_count", 3'(add_q.size() - base), 3'd2);
        check("t5_fresh", (add_q[base] - c0 == 17) ? 3'd1 : 3'd0, 3'd1);
        check("t5_repeat", (add_q[base + 1] - c0 == 27) ? 3'd1 : 3'd0, 3'd1);
        add_raw = 1'b0;
        tick(12);

        // 6: short glitches on every input
        base = start_cnt; base2 = stop_cnt; c1 = add_q.size();
        for (int b = 0; b < 3; b++) begin
            for (int w = 1; w <= 3; w += 2) begin
                if (b == 0) start_raw = 1'b1; else if (b == 1) stop_raw = 1'b1; else add_raw = 1'b1;
                tick(w);
                start_raw = 1'b0; stop_raw = 1'b0; add_raw = 1'b0;
                tick(6);
                check("t6_level", btn_level, 3'b000);
            end
        end
        check("t6_pulses", {3'(start_cnt - base) != 0, 3'(stop_cnt - base2) != 0,
                            (add_q.size() - c1) != 0}, 3'b000);

        // random soak
        for (int b = 0; b < 3; b++) begin hold_left[b] = 0; lvl[b] = 0; end
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    lvl[b] = 1'($urandom_range(0, 1));
                    hold_left[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                                               : $urandom_range(4, 40);
                end else begin
                    hold_left[b]--;
                end
            end
            start_raw = lvl[0]; stop_raw = lvl[1]; add_raw = lvl[2];
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 3));
                rst = 1'b0;
            end
            tick(1);
        end
        start_raw = 1'b0; stop_raw = 1'b0; add_raw = 1'b0;
        tick(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
